// File: rtl/spart_rx_fifo.sv
// spart_rx_fifo: 16x-oversampled serial receiver feeding a FWFT FIFO with per-word error flags.
// Optional parity bit after the data bits: define SPART_RX_PARITY_EN.
module spart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 8,
    parameter int DIV_W      = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rxd,
    input  logic [DIV_W-1:0]       divisor,
    input  logic                   rd_en,
    input  logic                   ovr_clr,
    output logic [DATA_W-1:0]      rdata,
    output logic                   frame_err,
    output logic                   parity_err,
    output logic                   rda,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun
);

`ifdef SPART_RX_PARITY_EN
    localparam int EW = DATA_W + 2;
`else
    localparam int EW = DATA_W + 1;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SPART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK_WAIT
    } state_t;

    logic sync1;
    logic rxd_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
        end
    end

    logic [DIV_W-1:0] tick_cnt;
    logic             tick;
    logic             start_go;

    assign tick = (tick_cnt == '0);

    // Reloading on START entry aligns the sample point to the start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tick_cnt <= divisor;
        else if (start_go || tick)
            tick_cnt <= divisor;
        else
            tick_cnt <= tick_cnt - 1'b1;
    end

    state_t            state_q, state_d;
    logic [3:0]        tcnt_q, tcnt_d;
    logic [BW-1:0]     bidx_q, bidx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              push;
`ifdef SPART_RX_PARITY_EN
    logic              perr_q, perr_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            bidx_q  <= '0;
            shreg_q <= '0;
`ifdef SPART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bidx_q  <= bidx_d;
            shreg_q <= shreg_d;
`ifdef SPART_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        bidx_d   = bidx_q;
        shreg_d  = shreg_q;
        start_go = 1'b0;
        push     = 1'b0;
`ifdef SPART_RX_PARITY_EN
        perr_d   = perr_q;
`endif
        if (tick)
            tcnt_d = tcnt_q + 4'd1;
        unique case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    state_d  = START;
                    tcnt_d   = '0;
                    bidx_d   = '0;
                    start_go = 1'b1;
                end
            end
            START: begin
                if (tick && tcnt_q == 4'd7) begin
                    tcnt_d  = '0;
                    state_d = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && tcnt_q == 4'd15) begin
                    shreg_d = {rxd_s, shreg_q[DATA_W-1:1]};
                    bidx_d  = bidx_q + 1'b1;
                    if (bidx_q == LAST_BIT) begin
`ifdef SPART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef SPART_RX_PARITY_EN
            PARITY: begin
                if (tick && tcnt_q == 4'd15) begin
                    perr_d  = ((^shreg_q) ^ rxd_s) != PARITY_ODD[0];
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick && tcnt_q == 4'd15) begin
                    push    = 1'b1;
                    state_d = rxd_s ? IDLE : BRK_WAIT;
                end
            end
            BRK_WAIT: begin
                if (rxd_s)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [EW-1:0] wr_entry;
`ifdef SPART_RX_PARITY_EN
    assign wr_entry = {perr_q, ~rxd_s, shreg_q};
`else
    assign wr_entry = {~rxd_s, shreg_q};
    wire unused_parity_odd = PARITY_ODD[0];
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] head;
    logic          pop;
    logic          wr_ok;

    assign rda   = (count != '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign pop   = rd_en && rda;
    // A pop in the same cycle frees the slot a full FIFO needs
    assign wr_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !pop)
                count <= count + 1'b1;
            else if (!wr_ok && pop)
                count <= count - 1'b1;
            if (push && !wr_ok)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

    assign head      = rda ? mem[rd_ptr] : '0;
    assign rdata     = head[DATA_W-1:0];
    assign frame_err = head[DATA_W];
`ifdef SPART_RX_PARITY_EN
    assign parity_err = head[DATA_W+1];
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_spart_rx_fifo.sv
// tb_spart_rx_fifo: line-level frame driver, queue scoreboard and read-side monitor.
// Honours SPART_RX_PARITY_EN the same way the design does.
`timescale 1ns/1ps
module tb_spart_rx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int DIV_W  = 16;
    localparam int PODD   = 0;
`ifdef SPART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             rxd = 1'b1;
    logic [DIV_W-1:0] divisor = '0;
    logic             rd_en = 1'b0;
    logic             ovr_clr = 1'b0;
    logic [7:0]       rdata;
    logic             frame_err;
    logic             parity_err;
    logic             rda;
    logic             full;
    logic [3:0]       count;
    logic             overrun;

    int   checks = 0;
    int   passed = 0;
    exp_t exp_q[$];
    bit   rd_allow = 0;
    bit   force_pop = 0;
    bit   exp_ovr = 0;
    int   lat = 155 + 16 * P;

    spart_rx_fifo #(
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .DIV_W(DIV_W),
        .PARITY_ODD(PODD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .divisor(divisor),
        .rd_en(rd_en),
        .ovr_clr(ovr_clr),
        .rdata(rdata),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .rda(rda),
        .full(full),
        .count(count),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic bit goodp(input logic [7:0] d);
        return (^d) ^ PODD[0];
    endfunction

    function automatic exp_t model(input logic [7:0] d, input bit stop, input bit pbit);
        exp_t e;
        e.data = d;
        e.ferr = !stop;
        e.perr = (P == 1) && ((($countones(d) + pbit) % 2) != PODD);
        return e;
    endfunction

    // Read side: pops whenever allowed and compares the head against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            rd_en = rd_allow || force_pop;
            if (rd_en && rda) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", int'(rdata), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", int'(rdata), int'(e.data));
                    chk("frame_err", int'(frame_err), int'(e.ferr));
                    chk("parity_err", int'(parity_err), int'(e.perr));
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input bit stop, input bit pbit,
                              input int hold_low, input bit fpop);
        int bp;
        bit acc;
        bp  = 16 * (int'(divisor) + 1);
        acc = rd_allow || fpop || (exp_q.size() < DEPTH);
        if (acc)
            exp_q.push_back(model(d, stop, pbit));
        else
            exp_ovr = 1;
        @(posedge clk);
        #1;
        fork
            begin
                rxd = 1'b0;
                repeat (bp) @(posedge clk);
                #1;
                for (int i = 0; i < DATA_W; i++) begin
                    rxd = d[i];
                    repeat (bp) @(posedge clk);
                    #1;
                end
                if (P == 1) begin
                    rxd = pbit;
                    repeat (bp) @(posedge clk);
                    #1;
                end
                rxd = stop;
                repeat (bp) @(posedge clk);
                #1;
                if (hold_low > 0) begin
                    rxd = 1'b0;
                    repeat (hold_low) @(posedge clk);
                    #1;
                end
                rxd = 1'b1;
                repeat (bp) @(posedge clk);
                #1;
            end
            begin
                if (fpop) begin
                    repeat (lat - 1) @(posedge clk);
                    #1 force_pop = 1;
                    @(posedge clk);
                    #1 force_pop = 0;
                end
            end
        join
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 8000) begin
            @(posedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_count"}, int'(count), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rda", int'(rda), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_rdata", int'(rdata), 0);
        chk("rst_ferr", int'(frame_err), 0);
        chk("rst_perr", int'(parity_err), 0);
        chk("rst_ovr", int'(overrun), 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single frame, latency and pop
        fork
            send_frame(8'hA5, 1, goodp(8'hA5), 0, 0);
            begin
                wait (rxd == 1'b0);
                n = 0;
                while (!rda && n < 400) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                checks++;
                if (n >= 152 + 16 * P && n <= 158 + 16 * P) begin
                    passed++;
                    lat = n;
                end else begin
                    $display("FAIL latency: got %0d cycles expected %0d..%0d",
                             n, 152 + 16 * P, 158 + 16 * P);
                end
            end
        join
        chk("t1_rda", int'(rda), 1);
        chk("t1_count", int'(count), 1);
        chk("t1_rdata", int'(rdata), 8'hA5);
        chk("t1_ferr", int'(frame_err), 0);
        rd_allow = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("t1_rda_after", int'(rda), 0);
        chk("t1_count_after", int'(count), 0);
        chk("t1_rdata_empty", int'(rdata), 0);

        // Start-bit glitch is rejected
        rd_allow = 0;
        rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("glitch_rda", int'(rda), 0);
        rd_allow = 1;

        // Framing error followed by a held break, then a normal frame
        send_frame(8'h3C, 0, goodp(8'h3C), 40 * 16, 0);
        send_frame(8'h11, 1, goodp(8'h11), 0, 0);
        drain("t3_drain");

        // Overrun on the ninth frame
        rd_allow = 0;
        exp_ovr = 0;
        for (int i = 0; i < 9; i++)
            send_frame(8'(i), 1, goodp(8'(i)), 0, 0);
        chk("t4_full", int'(full), 1);
        chk("t4_count", int'(count), 8);
        chk("t4_overrun", int'(overrun), int'(exp_ovr));
        @(posedge clk);
        #1 ovr_clr = 1;
        @(posedge clk);
        #1 ovr_clr = 0;
        exp_ovr = 0;
        chk("t4_ovr_clr", int'(overrun), 0);

        // Push into a full FIFO with a same-cycle pop
        send_frame(8'h55, 1, goodp(8'h55), 0, 1);
        chk("t5_count", int'(count), 8);
        chk("t5_full", int'(full), 1);
        chk("t5_overrun", int'(overrun), 0);
        rd_allow = 1;
        drain("t5_drain");
        chk("t5_rdata_empty", int'(rdata), 0);

        // Parity polarity (with parity enabled the model flags the second word)
        send_frame(8'h07, 1, 1, 0, 0);
        send_frame(8'h07, 1, 0, 0, 0);
        drain("t6_drain");

        // Randomised frames across divisors
        for (int k = 0; k < 25; k++) begin
            divisor = DIV_W'($urandom_range(0, 3));
            send_frame(8'($urandom), $urandom_range(0, 7) != 0,
                       1'($urandom_range(0, 1)), 0, 0);
        end
        drain("rand_drain");
        chk("final_overrun", int'(overrun), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/spart_rx_fifo.md
Name: spart_rx_fifo

Overview:
Parametrised SPART receive channel: a 16x-oversampled serial receiver with runtime baud divisor, configurable data width and a first-word-fall-through receive FIFO that carries per-word error flags.
- Successor to the fixed 8-bit, single-buffer SPART receive path.
- Sits between the rxd pin and the driver-facing bus logic; the bus side pops words through a simple read strobe.

Parameters:
DATA_W, 8, data bits per frame (5..9), LSB first on the line
DEPTH, 8, receive FIFO entries (power of 2, >=2)
DIV_W, 16, baud divisor width
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only with SPART_RX_PARITY_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
rxd  input  1  serial receive line, idle high, asynchronous to clk
divisor  input  DIV_W  sample-tick period minus 1, in clk cycles
rd_en  input  1  pop head word when rda=1
ovr_clr  input  1  clear sticky overrun flag
rdata  output  DATA_W  head-of-FIFO data
frame_err  output  1  head word had stop bit = 0
parity_err  output  1  head word failed parity check
rda  output  1  FIFO non-empty
full  output  1  FIFO full
count  output  $clog2(DEPTH)+1  words held
overrun  output  1  sticky: a frame was dropped because the FIFO was full

Behaviour:
- Reset (rst=0, async): FSM=IDLE; pointers and count=0; overrun=0; synchroniser flops=1; tick counter=divisor reload. Outputs: rda=0, full=0, rdata=0, frame_err=0, parity_err=0.
- Synchroniser: rxd passes through 2 flops (reset value 1). All decisions use the synchronised value.
- Tick generator: down-counter, reloads with divisor and pulses tick when it reaches 0. divisor=0 gives a tick every cycle. The new divisor takes effect at the next reload. The counter is reloaded when START is entered.
- FSM, with a 4-bit tick counter (tcnt) and a bit index:
  - IDLE: sync rxd==0 -> START, tcnt=0.
  - START: on the 8th tick, sample. If 0 -> DATA. If 1 -> IDLE (glitch rejected, nothing pushed).
  - DATA: sample every 16 ticks, shift in LSB first. After DATA_W bits -> PARITY (if enabled) else STOP.
  - PARITY: sample after 16 ticks; compute error -> STOP.
  - STOP: sample after 16 ticks, then push {parity_err, frame_err, data}. Stop=1 -> IDLE. Stop=0 -> BRK_WAIT.
  - BRK_WAIT: stay until sync rxd==1, then -> IDLE. Prevents re-triggering on a held break.
- FIFO:
  - rdata, frame_err and parity_err show the head entry combinationally while rda=1, and read 0 when empty.
  - Pop when rd_en && rda.
  - A push is accepted when !full, or when full with a same-cycle pop (count unchanged).
  - A push while full without a pop drops the word and sets overrun. overrun holds until ovr_clr=1.
  - ovr_clr and a new overrun in the same cycle: overrun stays 1 (set wins).
  - rd_en while empty is ignored; pointers and count do not change.
  - Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Latency: push occurs 2 synchroniser cycles plus (16*(1+DATA_W+P)+8) ticks after the falling edge, where P=1 with parity and 0 without. The word is visible on rda the cycle after the push.
- Reset mid-frame: the partial frame is discarded and FIFO contents are lost.

Optional Feature:
SPART_RX_PARITY_EN
- Defined: the PARITY state exists.
  - Received parity bit is XORed with the data bits; error when the result != PARITY_ODD.
  - parity_err is stored per word in the FIFO.
  - FIFO entries are DATA_W+2 bits wide.
- Undefined: no PARITY state; STOP follows the last data bit.
  - parity_err is tied to 0 and PARITY_ODD is ignored.
  - FIFO entries are DATA_W+1 bits wide.

Test Plan:
1. divisor=0, DATA_W=8, no parity: send 0xA5 with stop=1 -> rda rises after about 152 clk; rdata=0xA5, frame_err=0, count=1; rd_en for 1 cycle -> rda=0, count=0, rdata=0.
2. 2-cycle low pulse on rxd while IDLE -> START rejects it; no push; rda stays 0.
3. Send 0x3C with stop bit forced 0, then hold rxd low for 40 bit times -> exactly one word, rdata=0x3C, frame_err=1; the next frame 0x11 is received normally after rxd returns high.
4. DEPTH=8: send 9 frames 0x00..0x08 with no reads -> full=1, count=8, overrun=1; pops return 0x00..0x07 in order. ovr_clr -> overrun=0.
5. FIFO full with rd_en asserted on the push cycle of frame 0x55 -> count stays 8, overrun stays 0, 0x55 is the last word read out.
6. SPART_RX_PARITY_EN defined, PARITY_ODD=0: send 0x07 with parity bit 1 -> parity_err=0; send 0x07 with parity bit 0 -> parity_err=1.
